fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch-stage PC generator sitting directly upstream of branch_predictor: drives f_pc, consumes f_predict_valid/f_predict_addr.
//  Records every fetched PC with its prediction in an in-flight queue. Checks the queue against EXEC resolution and redirects on mispredict.
//  Emits x_predict_res, the actual branch outcome, back to the predictor.
// PARAMETERS
//  RESET_PC    32'h0000_1000  PC fetched after reset
//  QDEPTH      4              in-flight queue entries (power of 2, >=2); covers F->X distance
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  stall_f          in   1   downstream stall; hold f_pc, no queue push
//  f_predict_valid  in   1   predictor hit for current f_pc (same cycle, combinational)
//  f_predict_addr   in   32  predicted target for current f_pc
//  x_valid          in   1   EXEC resolves oldest in-flight instruction this cycle
//  x_pc             in   32  PC of the resolving instruction
//  x_is_branch      in   1   resolving instruction is a branch
//  x_taken          in   1   branch actually taken
//  x_target         in   32  actual branch target
//  f_pc             out  32  current fetch PC (registered)
//  f_valid          out  1   f_pc is a real fetch this cycle
//  x_predict_res    out  1   = x_valid & x_is_branch & x_taken (combinational)
//  x_mispredict     out  1   1-cycle pulse: resolution disagreed with recorded prediction
//  flush            out  1   registered copy of x_mispredict; kills F/D one cycle later
// BEHAVIOUR
//  - Reset (rst=1 at posedge): f_pc=RESET_PC, queue empty, flush=0, perf counters=0.
//    f_valid=0 while rst is high; x_mispredict=0 while rst is high. rst mid-operation discards all in-flight state.
//  - Queue entry = {pc, pred_taken, pred_addr}. Push when f_valid & ~stall_f & ~x_mispredict.
//    Pop when x_valid & queue non-empty. Push+pop in one cycle: both occur, count unchanged. Pointers wrap mod QDEPTH.
//  - f_valid = ~rst & ~full. There is no full-with-pop bypass.
//  - When full, f_pc holds and no push occurs.
//  - Next-PC priority at posedge (highest first):
//    1. rst: RESET_PC.
//    2. x_mispredict: actual_next.
//    3. stall_f or ~f_valid: hold.
//    4. f_predict_valid: f_predict_addr.
//    5. Otherwise: f_pc+4.
//  - Address arithmetic: +4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
//  - Resolution (x_valid & queue non-empty), head = oldest entry:
//    actual_next = (x_is_branch & x_taken) ? x_target : x_pc+4
//    pred_next   = head.pred_taken ? head.pred_addr : head.pc+4
//    x_mispredict = (actual_next != pred_next) | (x_pc != head.pc)
//  - On mispredict: entire queue cleared at posedge; the same-cycle fetch is not pushed.
//    f_pc=actual_next and f_valid=1 in the next cycle, so redirect latency is 1 cycle. flush=1 for exactly that cycle.
//  - x_valid with empty queue: ignored. No pop, x_mispredict=0; x_predict_res still reflects inputs.
//  - Back-to-back mispredicts cannot occur: the queue is empty after a redirect, so the next x_valid is ignored until a new push.
//  - Control FSM, state register 2 bits:
//    RESET -> RUN on the first cycle with rst=0.
//    RUN -> FULL when count==QDEPTH.
//    FULL -> RUN on a pop.
//    Any state -> RUN on mispredict.
//    Any state -> RESET on rst.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    adds ports perf_branches (out 32) and perf_mispredicts (out 32).
//    perf_branches increments on each popped resolution with x_is_branch=1.
//    perf_mispredicts increments on each x_mispredict.
//    Both saturate at 32'hFFFF_FFFF and clear on rst.
//  FETCH_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset and straight-line fetch:
//     rst 2 cycles, then no predictions, no stall.
//     -> f_valid=0 during rst; f_pc sequence 1000,1004,1008,100C; x_mispredict never 1.
//  2. Predicted-taken, confirmed:
//     f_pc=1008 with f_predict_valid=1, f_predict_addr=1010 -> next f_pc=1010.
//     Later x_valid, x_pc=1008, x_is_branch=1, x_taken=1, x_target=1010 -> x_predict_res=1, x_mispredict=0.
//  3. Predicted-not-taken, actually taken:
//     f_pc=1014, no hit, so 1018 fetched.
//     x_pc=1014 taken, x_target=1000 -> x_mispredict=1; next cycle f_pc=1000, flush=1, queue empty.
//  4. Predicted-taken, actually not taken:
//     f_pc=100C predicted to 1014.
//     x_pc=100C, x_taken=0 -> x_mispredict=1; next f_pc=1010.
//  5. Queue full and stall:
//     QDEPTH=4, no x_valid for 6 cycles.
//     -> f_valid=0 from the 5th fetch cycle, f_pc holds.
//     One x_valid -> f_valid=1 the next cycle.
//     stall_f=1 for 3 cycles -> f_pc constant, count constant.
//  6. Edge cases:
//     x_valid with empty queue -> no mispredict.
//     f_pc=FFFF_FFFC with no hit -> next f_pc=0000_0000.
//     rst asserted with 3 entries queued -> queue empty, next f_pc=RESET_PC.
//     With FETCH_PERF_CNT_EN, after scenarios 2–4: perf_branches=3, perf_mispredicts=2.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch/execute bus between fetch_pc_gen and its neighbours.
// master = PC generator side, slave = predictor/EXEC/testbench side.
interface fetch_pc_gen_if;
    logic        stall_f;
    logic        f_predict_valid;
    logic [31:0] f_predict_addr;
    logic        x_valid;
    logic [31:0] x_pc;
    logic        x_is_branch;
    logic        x_taken;
    logic [31:0] x_target;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        x_predict_res;
    logic        x_mispredict;
    logic        flush;

    modport master (
        input  stall_f, f_predict_valid, f_predict_addr,
        input  x_valid, x_pc, x_is_branch, x_taken, x_target,
        output f_pc, f_valid, x_predict_res, x_mispredict, flush
    );

    modport slave (
        output stall_f, f_predict_valid, f_predict_addr,
        output x_valid, x_pc, x_is_branch, x_taken, x_target,
        input  f_pc, f_valid, x_predict_res, x_mispredict, flush
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with in-flight prediction queue and mispredict redirect.
// Optional FETCH_PERF_CNT_EN adds saturating branch/mispredict counters.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_pc_gen_if.master       bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_branches,
    output logic [31:0]          perf_mispredicts
`endif
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     f_pc_q, f_pc_d;
    logic            flush_q, flush_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     q_pc_q [QDEPTH];
    logic [31:0]     q_pc_d [QDEPTH];
    logic            q_pt_q [QDEPTH];
    logic            q_pt_d [QDEPTH];
    logic [31:0]     q_pa_q [QDEPTH];
    logic [31:0]     q_pa_d [QDEPTH];

    logic            full;
    logic            empty;
    logic            f_valid;
    logic            resolve;
    logic            mispredict;
    logic            push;
    logic            pop;
    logic [31:0]     head_pc;
    logic            head_pt;
    logic [31:0]     head_pa;
    logic [31:0]     actual_next;
    logic [31:0]     pred_next;

    always_comb begin
        full        = (count_q == FULL_CNT);
        empty       = (count_q == '0);
        f_valid     = ~rst & ~full;
        head_pc     = q_pc_q[rd_ptr_q];
        head_pt     = q_pt_q[rd_ptr_q];
        head_pa     = q_pa_q[rd_ptr_q];
        actual_next = (bus.x_is_branch & bus.x_taken) ? bus.x_target : bus.x_pc + 32'd4;
        pred_next   = head_pt ? head_pa : head_pc + 32'd4;
        resolve     = ~rst & bus.x_valid & ~empty;
        // A PC mismatch means the queue has lost sync with EXEC; treat it as a redirect too.
        mispredict  = resolve & ((actual_next != pred_next) | (bus.x_pc != head_pc));
        push        = f_valid & ~bus.stall_f & ~mispredict;
        pop         = resolve;
    end

    always_comb begin
        q_pc_d   = q_pc_q;
        q_pt_d   = q_pt_q;
        q_pa_d   = q_pa_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispredict) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q] = f_pc_q;
                q_pt_d[wr_ptr_q] = bus.f_predict_valid;
                q_pa_d[wr_ptr_q] = bus.f_predict_addr;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        f_pc_d  = f_pc_q;
        flush_d = mispredict;
        if (mispredict) begin
            f_pc_d = actual_next;
        end else if (bus.stall_f | ~f_valid) begin
            f_pc_d = f_pc_q;
        end else if (bus.f_predict_valid) begin
            f_pc_d = bus.f_predict_addr;
        end else begin
            f_pc_d = f_pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   if (count_q == FULL_CNT) state_d = S_FULL;
            S_FULL:  if (pop) state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
        if (mispredict) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            f_pc_q   <= RESET_PC;
            flush_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_pc_q   <= '{default: '0};
            q_pt_q   <= '{default: 1'b0};
            q_pa_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            f_pc_q   <= f_pc_d;
            flush_q  <= flush_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_pc_q   <= q_pc_d;
            q_pt_q   <= q_pt_d;
            q_pa_q   <= q_pa_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mp_q, perf_mp_d;

    always_comb begin
        perf_br_d = perf_br_q;
        perf_mp_d = perf_mp_q;
        if (pop & bus.x_is_branch & (perf_br_q != 32'hFFFF_FFFF)) begin
            perf_br_d = perf_br_q + 32'd1;
        end
        if (mispredict & (perf_mp_q != 32'hFFFF_FFFF)) begin
            perf_mp_d = perf_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`endif

    assign bus.f_pc          = f_pc_q;
    assign bus.f_valid       = f_valid;
    assign bus.x_predict_res = bus.x_valid & bus.x_is_branch & bus.x_taken;
    assign bus.x_mispredict  = mispredict;
    assign bus.flush         = flush_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios with literal checks, then random traffic
// compared every cycle against a queue-based reference model.
module tb_fetch_pc_gen;
    localparam logic [31:0] RPC = 32'h0000_1000;
    localparam int QD = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    fetch_pc_gen_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_b;
    logic [31:0] perf_m;
    logic [31:0] m_pb;
    logic [31:0] m_pm;
`endif

    fetch_pc_gen #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_branches(perf_b),
        .perf_mispredicts(perf_m)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] pa;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc    = RPC;
    logic        m_flush = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, then advanced to the state after the next edge.
    always @(negedge clk) begin : model
        logic        e_fv, e_res, e_mis, e_xpr;
        logic [31:0] act_n, pred_n;
        ent_t        ne;
        e_fv  = !rst && (m_q.size() < QD);
        e_xpr = bus.x_valid && bus.x_is_branch && bus.x_taken;
        e_res = !rst && bus.x_valid && (m_q.size() > 0);
        act_n = (bus.x_is_branch && bus.x_taken) ? bus.x_target : bus.x_pc + 32'd4;
        e_mis = 1'b0;
        if (e_res) begin
            pred_n = m_q[0].pt ? m_q[0].pa : m_q[0].pc + 32'd4;
            e_mis  = (act_n != pred_n) || (bus.x_pc != m_q[0].pc);
        end
        chk("f_pc", bus.f_pc, m_pc);
        chk1("f_valid", bus.f_valid, e_fv);
        chk1("x_predict_res", bus.x_predict_res, e_xpr);
        chk1("x_mispredict", bus.x_mispredict, e_mis);
        chk1("flush", bus.flush, m_flush);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_branches", perf_b, m_pb);
        chk("perf_mispredicts", perf_m, m_pm);
`endif
        if (rst) begin
            m_pc    = RPC;
            m_flush = 1'b0;
            m_q.delete();
`ifdef FETCH_PERF_CNT_EN
            m_pb = '0;
            m_pm = '0;
`endif
        end else begin
            m_flush = e_mis;
`ifdef FETCH_PERF_CNT_EN
            if (e_res && bus.x_is_branch && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
            if (e_mis && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
`endif
            if (e_mis) begin
                m_q.delete();
                m_pc = act_n;
            end else begin
                if (e_res) void'(m_q.pop_front());
                if (e_fv && !bus.stall_f) begin
                    ne.pc = m_pc;
                    ne.pt = bus.f_predict_valid;
                    ne.pa = bus.f_predict_addr;
                    m_q.push_back(ne);
                    m_pc = bus.f_predict_valid ? bus.f_predict_addr : m_pc + 32'd4;
                end
            end
        end
    end

    task automatic drv(input logic s, input logic pv, input logic [31:0] pa,
                       input logic xv, input logic [31:0] xp, input logic br,
                       input logic tk, input logic [31:0] tg);
        bus.stall_f         = s;
        bus.f_predict_valid = pv;
        bus.f_predict_addr  = pa;
        bus.x_valid         = xv;
        bus.x_pc            = xp;
        bus.x_is_branch     = br;
        bus.x_taken         = tk;
        bus.x_target        = tg;
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] xp, tg;
`ifdef FETCH_PERF_CNT_EN
        m_pb = '0;
        m_pm = '0;
`endif
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rst f_valid", bus.f_valid, 1'b0);
        chk("rst f_pc", bus.f_pc, 32'h1000);
        nxt();
        rst = 1'b0;
        // c0..c5: straight-line, confirmed taken, then not-predicted taken branch
        drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("c0 f_pc", bus.f_pc, 32'h1000); chk1("c0 f_valid", bus.f_valid, 1'b1);
        nxt(); drv(0, 0, 0, 1, 32'h1000, 0, 0, 0);
        @(negedge clk); chk("c1 f_pc", bus.f_pc, 32'h1004);
        nxt(); drv(0, 1, 32'h1010, 1, 32'h1004, 0, 0, 0);
        @(negedge clk); chk("c2 f_pc", bus.f_pc, 32'h1008);
        nxt(); drv(0, 0, 0, 1, 32'h1008, 1, 1, 32'h1010);
        @(negedge clk); chk("c3 f_pc", bus.f_pc, 32'h1010);
        chk1("c3 x_predict_res", bus.x_predict_res, 1'b1);
        chk1("c3 x_mispredict", bus.x_mispredict, 1'b0);
        nxt(); drv(0, 0, 0, 1, 32'h1010, 0, 0, 0);
        @(negedge clk); chk("c4 f_pc", bus.f_pc, 32'h1014);
        nxt(); drv(0, 0, 0, 1, 32'h1014, 1, 1, 32'h1000);
        @(negedge clk); chk("c5 f_pc", bus.f_pc, 32'h1018); chk1("c5 x_mispredict", bus.x_mispredict, 1'b1);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("c6 f_pc", bus.f_pc, 32'h1000); chk1("c6 flush", bus.flush, 1'b1);
        nxt(); drv(0, 0, 0, 1, 32'h1000, 0, 0, 0);
        @(negedge clk); chk("c7 f_pc", bus.f_pc, 32'h1004); chk1("c7 flush", bus.flush, 1'b0);
        nxt(); drv(0, 0, 0, 1, 32'h1004, 0, 0, 0);
        @(negedge clk); chk("c8 f_pc", bus.f_pc, 32'h1008);
        nxt(); drv(0, 1, 32'h1014, 1, 32'h1008, 0, 0, 0);
        @(negedge clk); chk("c9 f_pc", bus.f_pc, 32'h100C);
        // predicted taken but falls through
        nxt(); drv(0, 0, 0, 1, 32'h100C, 1, 0, 0);
        @(negedge clk); chk("c10 f_pc", bus.f_pc, 32'h1014); chk1("c10 x_mispredict", bus.x_mispredict, 1'b1);
        // resolution against an empty queue is ignored
        nxt(); drv(0, 0, 0, 1, 32'h1234, 1, 1, 32'h5678);
        @(negedge clk); chk("c11 f_pc", bus.f_pc, 32'h1010); chk1("c11 flush", bus.flush, 1'b1);
        chk1("c11 x_mispredict", bus.x_mispredict, 1'b0); chk1("c11 x_predict_res", bus.x_predict_res, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("c11 perf_branches", perf_b, 32'd3);
        chk("c11 perf_mispredicts", perf_m, 32'd2);
`endif
        // fill the queue
        for (int i = 12; i <= 14; i++) begin
            nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 15; i <= 16; i++) begin
            nxt();
            @(negedge clk); chk1("full f_valid", bus.f_valid, 1'b0); chk("full f_pc", bus.f_pc, 32'h1020);
        end
        nxt(); drv(0, 0, 0, 1, 32'h1010, 0, 0, 0);
        @(negedge clk); chk1("c17 f_valid", bus.f_valid, 1'b0); chk1("c17 x_mispredict", bus.x_mispredict, 1'b0);
        for (int i = 18; i <= 20; i++) begin
            nxt(); drv(1, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk); chk1("stall f_valid", bus.f_valid, 1'b1); chk("stall f_pc", bus.f_pc, 32'h1020);
        end
        nxt(); drv(0, 1, 32'hFFFF_FFFC, 1, 32'h1014, 0, 0, 0);
        @(negedge clk); chk("c21 f_pc", bus.f_pc, 32'h1020);
        nxt(); drv(0, 0, 0, 1, 32'h1018, 0, 0, 0);
        @(negedge clk); chk("c22 f_pc", bus.f_pc, 32'hFFFF_FFFC);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("c23 wrap f_pc", bus.f_pc, 32'h0000_0000);
        // reset with a populated queue, with a would-be mispredict on the bus
        nxt(); rst = 1'b1; drv(0, 0, 0, 1, 32'h101C, 1, 1, 32'h9999);
        @(negedge clk); chk1("c24 f_valid", bus.f_valid, 1'b0); chk1("c24 x_mispredict", bus.x_mispredict, 1'b0);
        nxt(); rst = 1'b0; drv(0, 0, 0, 1, 32'h0, 1, 1, 32'h40);
        @(negedge clk); chk("c25 f_pc", bus.f_pc, 32'h1000); chk1("c25 f_valid", bus.f_valid, 1'b1);
        chk1("c25 x_mispredict", bus.x_mispredict, 1'b0); chk1("c25 flush", bus.flush, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            nxt();
            rst = ($urandom_range(0, 199) == 0);
            xp = {$urandom_range(0, 255), 2'b00};
            tg = {$urandom_range(0, 255), 2'b00};
            if (m_q.size() > 0 && $urandom_range(0, 9) != 0) begin
                xp = m_q[0].pc;
                if ($urandom_range(0, 1) == 1) tg = m_q[0].pa;
            end
            drv($urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0,
                ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {22'd0, $urandom_range(0, 255), 2'b00},
                $urandom_range(0, 1) == 1,
                xp,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1,
                tg);
        end
        nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
